// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// ---------------------------------------------------------------------------
// Parametrised VGA raster timing generator. Free-running pixel (hcount) and
// line (vcount) counters advance on clk edges with en=1, and produce sync,
// blank, end-of-line and start-of-frame strobes for the draw pipeline.
//
// Every output is a register. The strobes are decoded from the *next*
// counter values and loaded in the same edge as the counters, so they always
// line up with hcount/vcount in the same cycle.
//
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit
// frame_cnt output. It advances on the same edge that schedules sof.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   pixel enable; the raster advances only when en=1
//   hcount     out  current pixel column (CNT_W bits)
//   vcount     out  current line (CNT_W bits)
//   hsync      out  horizontal sync, active level HSYNC_POL
//   vsync      out  vertical sync, active level VSYNC_POL
//   hblnk      out  hcount >= HOR_PIXELS
//   vblnk      out  vcount >= VER_PIXELS
//   sof        out  one-clk pulse after the wrap to (0,0)
//   eol        out  hcount == HOR_TOTAL-1
//   frame_cnt  out  16-bit frame counter (VGA_TIMING_FRAME_CNT_EN only)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   HOR_PIXELS     = 1024,
    parameter int   HOR_SYNC_START = 1048,
    parameter int   HOR_SYNC_END   = 1184,
    parameter int   HOR_TOTAL      = 1344,
    parameter int   VER_PIXELS     = 768,
    parameter int   VER_SYNC_START = 771,
    parameter int   VER_SYNC_END   = 777,
    parameter int   VER_TOTAL      = 806,
    parameter logic HSYNC_POL      = 1'b1,
    parameter logic VSYNC_POL      = 1'b1,
    parameter int   CNT_W          = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             sof,
    output logic             eol
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HOR_TOTAL - 32'd1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VER_TOTAL - 32'd1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(HOR_PIXELS);
    localparam logic [CNT_W-1:0] H_SS     = CNT_W'(HOR_SYNC_START);
    localparam logic [CNT_W-1:0] H_SE     = CNT_W'(HOR_SYNC_END);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(VER_PIXELS);
    localparam logic [CNT_W-1:0] V_SS     = CNT_W'(VER_SYNC_START);
    localparam logic [CNT_W-1:0] V_SE     = CNT_W'(VER_SYNC_END);

    // Reject parameter sets that cannot form a valid raster.
    if (!((HOR_PIXELS < HOR_SYNC_START) && (HOR_SYNC_START < HOR_SYNC_END) &&
          (HOR_SYNC_END <= HOR_TOTAL))) begin : g_hor_order_bad
        $error("vga_timing_gen: horizontal timing order violated");
    end
    if (!((VER_PIXELS < VER_SYNC_START) && (VER_SYNC_START < VER_SYNC_END) &&
          (VER_SYNC_END <= VER_TOTAL))) begin : g_ver_order_bad
        $error("vga_timing_gen: vertical timing order violated");
    end
    if (((64'd1 << CNT_W) < 64'(HOR_TOTAL)) ||
        ((64'd1 << CNT_W) < 64'(VER_TOTAL))) begin : g_cnt_w_bad
        $error("vga_timing_gen: CNT_W too small for HOR_TOTAL/VER_TOTAL");
    end

    logic [CNT_W-1:0] hcount_r, vcount_r;
    logic [CNT_W-1:0] hcount_nxt_s, vcount_nxt_s;
    logic             hsync_r, vsync_r, hblnk_r, vblnk_r, sof_r, eol_r;
    logic             hsync_nxt_s, vsync_nxt_s, hblnk_nxt_s, vblnk_nxt_s, eol_nxt_s;
    logic             frame_wrap_s;

    // Next raster position: wrap by explicit compare, hold when en=0.
    always_comb begin
        hcount_nxt_s = hcount_r;
        vcount_nxt_s = vcount_r;
        frame_wrap_s = 1'b0;
        if (en) begin
            if (hcount_r == H_LAST) begin
                hcount_nxt_s = CNT_ZERO;
                if (vcount_r == V_LAST) begin
                    vcount_nxt_s = CNT_ZERO;
                    frame_wrap_s = 1'b1;
                end else begin
                    vcount_nxt_s = vcount_r + CNT_ONE;
                end
            end else begin
                hcount_nxt_s = hcount_r + CNT_ONE;
            end
        end else begin
            hcount_nxt_s = hcount_r;
            vcount_nxt_s = vcount_r;
        end
    end

    // Strobes decoded from the next position so they register alongside it.
    always_comb begin
        hsync_nxt_s = ((hcount_nxt_s >= H_SS) && (hcount_nxt_s < H_SE)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_nxt_s = ((vcount_nxt_s >= V_SS) && (vcount_nxt_s < V_SE)) ? VSYNC_POL : ~VSYNC_POL;
        hblnk_nxt_s = (hcount_nxt_s >= H_VIS);
        vblnk_nxt_s = (vcount_nxt_s >= V_VIS);
        eol_nxt_s   = (hcount_nxt_s == H_LAST);
    end

    // Raster state register; sof is reloaded every clk so it lasts one cycle
    // even when en drops right after the frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_r <= CNT_ZERO;
            vcount_r <= CNT_ZERO;
            hsync_r  <= ~HSYNC_POL;
            vsync_r  <= ~VSYNC_POL;
            hblnk_r  <= 1'b0;
            vblnk_r  <= 1'b0;
            eol_r    <= 1'b0;
            sof_r    <= 1'b0;
        end else begin
            hcount_r <= hcount_nxt_s;
            vcount_r <= vcount_nxt_s;
            hsync_r  <= hsync_nxt_s;
            vsync_r  <= vsync_nxt_s;
            hblnk_r  <= hblnk_nxt_s;
            vblnk_r  <= vblnk_nxt_s;
            eol_r    <= eol_nxt_s;
            sof_r    <= frame_wrap_s;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frame counter, advanced by the same edge that schedules sof; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

    assign hcount = hcount_r;
    assign vcount = vcount_r;
    assign hsync  = hsync_r;
    assign vsync  = vsync_r;
    assign hblnk  = hblnk_r;
    assign vblnk  = vblnk_r;
    assign sof    = sof_r;
    assign eol    = eol_r;

endmodule
